// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes ALUOp/funct into the ALU control code, selects operand B,
// and registers everything into EX with stall/flush handling and an illegal-op counter.
module id_ex_alu_issue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [1:0]       id_alu_op,
    input  logic [5:0]       id_funct,
    input  logic             id_alu_src,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [3:0]       ex_alu_control,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [1:0] {
        OP_MEM    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_RTYPE  = 2'b10,
        OP_RSVD   = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        CTL_AND = 4'b0000,
        CTL_OR  = 4'b0001,
        CTL_ADD = 4'b0010,
        CTL_SUB = 4'b0110,
        CTL_BAD = 4'b1111
    } alu_ctl_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101
    } funct_t;

    alu_ctl_t         w_ctl;
    logic             w_illegal;
    logic [WIDTH-1:0] w_b;
    logic             w_load;

    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    alu_ctl_t         r_ctl;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    // funct is only consulted for R-type; every other ALUOp ignores it
    always_comb begin
        w_ctl     = CTL_ADD;
        w_illegal = 1'b0;
        unique case (alu_op_t'(id_alu_op))
            OP_MEM:    w_ctl = CTL_ADD;
            OP_BRANCH: w_ctl = CTL_SUB;
            OP_RTYPE: begin
                case (id_funct)
                    FN_ADD:  w_ctl = CTL_ADD;
                    FN_SUB:  w_ctl = CTL_SUB;
                    FN_AND:  w_ctl = CTL_AND;
                    FN_OR:   w_ctl = CTL_OR;
                    default: begin
                        w_ctl     = CTL_BAD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            OP_RSVD: begin
                w_ctl     = CTL_BAD;
                w_illegal = 1'b1;
            end
            default: begin
                w_ctl     = CTL_BAD;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_b    = id_alu_src ? id_imm : id_rt_data;
    assign w_load = !flush && !stall && id_valid;

    // Flush and an invalid ID slot both load the same bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_ctl     <= CTL_ADD;
            r_illegal <= 1'b0;
        end else if (flush || (!stall && !id_valid)) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_ctl     <= CTL_ADD;
            r_illegal <= 1'b0;
        end else if (!stall) begin
            r_valid   <= 1'b1;
            r_a       <= id_rs_data;
            r_b       <= w_b;
            r_ctl     <= w_ctl;
            r_illegal <= w_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_load && w_illegal && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_a           = r_a;
    assign ex_b           = r_b;
    assign ex_alu_control = r_ctl;
    assign ex_illegal     = r_illegal;
    assign illegal_count  = r_cnt;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: decode, operand select, stall/flush priority,
// illegal-op counting, and counter saturation on a narrow-counter instance.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid, id_alu_src;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [31:0] id_rs_data, id_rt_data, id_imm;

    logic        ex_valid, ex_illegal;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_alu_control;
    logic [7:0]  illegal_count;

    logic        s_valid, s_illegal;
    logic [31:0] s_a, s_b;
    logic [3:0]  s_ctl;
    logic [1:0]  s_count;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_alu_control(ex_alu_control), .ex_illegal(ex_illegal),
        .illegal_count(illegal_count)
    );

    id_ex_alu_issue #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .ex_valid(s_valid), .ex_a(s_a), .ex_b(s_b),
        .ex_alu_control(s_ctl), .ex_illegal(s_illegal),
        .illegal_count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic src, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm);
        id_valid   = v;
        id_alu_op  = op;
        id_funct   = fn;
        id_alu_src = src;
        id_rs_data = rs;
        id_rt_data = rt;
        id_imm     = imm;
    endtask

    logic [5:0] fn_tab [3] = '{6'b100000, 6'b100010, 6'b100101};
    logic [3:0] ct_tab [3] = '{4'b0010, 4'b0110, 4'b0001};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 2'b10, 6'b101010, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D);
        step();
        step();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_a", ex_a, 32'd0);
        chk("rst_b", ex_b, 32'd0);
        chk("rst_ctl", {28'd0, ex_alu_control}, 32'h2);
        chk("rst_ill", {31'd0, ex_illegal}, 32'd0);
        chk("rst_cnt", {24'd0, illegal_count}, 32'd0);

        reset = 1'b0;
        drive(1'b1, 2'b10, 6'b100100, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000004);
        step();
        chk("and_ctl", {28'd0, ex_alu_control}, 32'h0);
        chk("and_a", ex_a, 32'hF0F0F0F0);
        chk("and_b", ex_b, 32'h0FF00FF0);
        chk("and_valid", {31'd0, ex_valid}, 32'd1);
        chk("and_ill", {31'd0, ex_illegal}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, fn_tab[i], 1'b0, 32'h00000100 + i, 32'h00000200 + i, 32'h0);
            step();
            chk("rtype_ctl", {28'd0, ex_alu_control}, {28'd0, ct_tab[i]});
            chk("rtype_b", ex_b, 32'h00000200 + i);
        end

        // immediate path; funct garbage must be ignored for ALUOp 00
        drive(1'b1, 2'b00, 6'b101010, 1'b1, 32'h00001000, 32'h55555555, 32'hFFFFFFFC);
        step();
        chk("imm_b", ex_b, 32'hFFFFFFFC);
        chk("imm_ctl", {28'd0, ex_alu_control}, 32'h2);
        chk("imm_ill", {31'd0, ex_illegal}, 32'd0);

        drive(1'b1, 2'b01, 6'b000000, 1'b0, 32'h00000007, 32'h00000003, 32'hFFFFFFFF);
        step();
        chk("br_ctl", {28'd0, ex_alu_control}, 32'h6);
        chk("br_b", ex_b, 32'h00000003);

        drive(1'b1, 2'b00, 6'b0, 1'b0, 32'h00000011, 32'h00000022, 32'h0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 6'b100010, 1'b1, 32'hAAAA0000 + i, 32'hBBBB0000, 32'hCCCC0000 + i);
            step();
            chk("stall_a", ex_a, 32'h00000011);
            chk("stall_b", ex_b, 32'h00000022);
            chk("stall_ctl", {28'd0, ex_alu_control}, 32'h2);
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        end
        flush = 1'b1;
        step();
        chk("sflush_valid", {31'd0, ex_valid}, 32'd0);
        chk("sflush_ctl", {28'd0, ex_alu_control}, 32'h2);
        chk("sflush_a", ex_a, 32'd0);
        stall = 1'b0; flush = 1'b0;

        drive(1'b1, 2'b10, 6'b101010, 1'b0, 32'h1, 32'h2, 32'h3);
        step();
        chk("ill1_ill", {31'd0, ex_illegal}, 32'd1);
        chk("ill1_ctl", {28'd0, ex_alu_control}, 32'hF);
        chk("ill1_cnt", {24'd0, illegal_count}, 32'd1);
        drive(1'b1, 2'b11, 6'b100000, 1'b0, 32'h1, 32'h2, 32'h3);
        step();
        chk("ill2_ill", {31'd0, ex_illegal}, 32'd1);
        chk("ill2_ctl", {28'd0, ex_alu_control}, 32'hF);
        chk("ill2_cnt", {24'd0, illegal_count}, 32'd2);

        id_valid = 1'b0;
        step();
        chk("inv_cnt", {24'd0, illegal_count}, 32'd2);
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_ill", {31'd0, ex_illegal}, 32'd0);
        id_valid = 1'b1; stall = 1'b1;
        step();
        chk("stl_cnt", {24'd0, illegal_count}, 32'd2);
        stall = 1'b0; flush = 1'b1;
        step();
        chk("fl_cnt", {24'd0, illegal_count}, 32'd2);
        chk("fl_ill", {31'd0, ex_illegal}, 32'd0);
        flush = 1'b0;

        // reset while stalled must still clear everything
        stall = 1'b1; reset = 1'b1;
        step();
        chk("rstst_cnt", {24'd0, illegal_count}, 32'd0);
        chk("rstst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rstst_scnt", {30'd0, s_count}, 32'd0);
        stall = 1'b0; reset = 1'b0;

        drive(1'b1, 2'b11, 6'b0, 1'b0, 32'h9, 32'h8, 32'h7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_cnt", {30'd0, s_count}, {30'd0, sat_exp[i]});
        end
        chk("wide_cnt", {24'd0, illegal_count}, 32'd5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
